decim_seq_ctrl: RTL and testbench

Programmable segment scheduler for the laser timing chain. It owns a clock-decimation divider and steps it through up to NSEG configured segments. Each segment has its own decimation factor and tick count. The block emits single-cycle `tick` strobes that pace downstream laser pulse logic, and it can run one-shot or loop the segment list continuously.

---
 rtl/decim_seq_ctrl.sv | 116 +++++++++++
 tb/tb_decim_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_seq_ctrl.sv
// decim_seq_ctrl: segment scheduler stepping a decimation divider through a table of {D, C} segments
module decim_seq_ctrl #(
  parameter int NSEG = 4,
  parameter int DW = 32,
  parameter int CW = 16,
  localparam int AW = $clog2(NSEG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_div,
  input  logic [CW-1:0] cfg_cnt,
  input  logic [AW-1:0] last_seg,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          tick,
  output logic          done,
  output logic [AW-1:0] seg_idx,
  output logic [CW-1:0] tick_idx
);
  // LAST holds busy for the cycle of the final tick so done lands one cycle later
  typedef enum logic [2:0] {IDLE, LOAD, RUN, LAST, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] tbl_d [NSEG];
  logic [CW-1:0] tbl_c [NSEG];
  logic [DW-1:0] d_lim, d_nx, cnt, cnt_nx;
  logic [CW-1:0] c_lim, c_nx, tidx_nx, tidx_inc;
  logic [AW-1:0] seg_nx, adv_seg;
  logic          tick_nx, adv_go;
  assign busy = (state == LOAD) || (state == RUN) || (state == LAST);
  assign done = state == DONE;
  assign adv_go = (seg_idx != last_seg) || loop;
  assign adv_seg = (seg_idx != last_seg) ? seg_idx + AW'(1) : loop ? '0 : seg_idx;
  assign tidx_inc = tick_idx + CW'(1);
  // segment table, writable at any time; the running segment only sees it at its next LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        tbl_d[i] <= DW'(1);
        tbl_c[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_d[cfg_addr] <= cfg_div;
      tbl_c[cfg_addr] <= cfg_cnt;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // datapath registers: shadow D-1/C, divider counter, indices and the tick strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_lim <= '0;
      c_lim <= '0;
      cnt <= '0;
      seg_idx <= '0;
      tick_idx <= '0;
      tick <= 1'b0;
    end else begin
      d_lim <= d_nx;
      c_lim <= c_nx;
      cnt <= cnt_nx;
      seg_idx <= seg_nx;
      tick_idx <= tidx_nx;
      tick <= tick_nx;
    end
  end
  // next-state and datapath updates; D is stored as D-1 (D=0 behaves as D=1) so no compare overflows
  always_comb begin
    state_nx = state;
    seg_nx = seg_idx;
    tidx_nx = tick_idx;
    tick_nx = 1'b0;
    cnt_nx = cnt;
    d_nx = d_lim;
    c_nx = c_lim;
    case (state)
      IDLE: if (start) begin
        seg_nx = '0;
        state_nx = LOAD;
      end
      LOAD: begin
        d_nx = (tbl_d[seg_idx] == '0) ? '0 : tbl_d[seg_idx] - DW'(1);
        c_nx = tbl_c[seg_idx];
        cnt_nx = '0;
        tidx_nx = '0;
        if (tbl_c[seg_idx] == '0) begin
          seg_nx = adv_seg;
          state_nx = adv_go ? LOAD : DONE;
        end else state_nx = RUN;
      end
      RUN: if (cnt == d_lim) begin
        cnt_nx = '0;
        tick_nx = 1'b1;
        tidx_nx = tidx_inc;
        if (tidx_inc == c_lim) begin
          seg_nx = adv_seg;
          state_nx = adv_go ? LOAD : LAST;
        end
      end else cnt_nx = cnt + DW'(1);
      LAST: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (stop) begin
      state_nx = IDLE;
      tick_nx = 1'b0;
      seg_nx = seg_idx;
      tidx_nx = tick_idx;
    end
  end
endmodule

// File: tb/tb_decim_seq_ctrl.sv
// tb_decim_seq_ctrl: directed-vector bench for decim_seq_ctrl
module tb_decim_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_div = '0;
  logic [15:0] cfg_cnt = '0;
  logic [1:0]  last_seg = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, tick, done;
  logic [1:0]  seg_idx;
  logic [15:0] tick_idx;
  int n_vec = 0;
  int n_err = 0;

  decim_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_div(cfg_div), .cfg_cnt(cfg_cnt), .last_seg(last_seg), .loop(loop),
    .start(start), .stop(stop), .busy(busy), .tick(tick), .done(done),
    .seg_idx(seg_idx), .tick_idx(tick_idx)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [15:0] c);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_div = d;
    cfg_cnt = c;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, tick, done, seg_idx, tick_idx} !== 21'd0) begin
      n_err++;
      $display("FAIL reset got b%b t%b d%b s%0d i%0d exp all 0", busy, tick, done, seg_idx, tick_idx);
    end
  endtask

  task automatic test_single();
    logic [2:0] e;
    wr(2'd0, 32'd3, 16'd4);
    last_seg = 2'd0;
    loop = 1'b0;
    kick();
    for (int r = 0; r < 16; r++) begin
      if (r > 0) @(negedge clk);
      e = {r <= 13, r == 4 || r == 7 || r == 10 || r == 13, r == 14};
      n_vec++;
      if ({busy, tick, done} !== e) begin
        n_err++;
        $display("FAIL single r=%0d got btd=%b exp=%b", r, {busy, tick, done}, e);
      end
    end
    n_vec++;
    if (tick_idx !== 16'd4) begin
      n_err++;
      $display("FAIL single_tick_idx got %0d exp 4", tick_idx);
    end
  endtask

  task automatic test_multi_skip();
    logic [4:0] e;
    logic [1:0] es;
    wr(2'd0, 32'd2, 16'd2);
    wr(2'd1, 32'd5, 16'd0);
    wr(2'd2, 32'd1, 16'd3);
    last_seg = 2'd2;
    loop = 1'b0;
    kick();
    for (int r = 0; r < 13; r++) begin
      if (r > 0) @(negedge clk);
      es = (r < 5) ? 2'd0 : (r == 5) ? 2'd1 : 2'd2;
      e = {r <= 10, r == 3 || r == 5 || r == 8 || r == 9 || r == 10, r == 11, es};
      n_vec++;
      if ({busy, tick, done, seg_idx} !== e) begin
        n_err++;
        $display("FAIL multi r=%0d got btds=%b exp=%b", r, {busy, tick, done, seg_idx}, e);
      end
      if (r == 5 || r == 10) begin
        n_vec++;
        if (tick_idx !== ((r == 5) ? 16'd2 : 16'd3)) begin
          n_err++;
          $display("FAIL multi_tick_idx r=%0d got %0d exp %0d", r, tick_idx, (r == 5) ? 2 : 3);
        end
      end
    end
  endtask

  task automatic test_loop();
    logic [2:0] e;
    wr(2'd0, 32'd4, 16'd2);
    last_seg = 2'd0;
    loop = 1'b1;
    kick();
    for (int r = 0; r < 26; r++) begin
      if (r > 0) @(negedge clk);
      e = {1'b1, r == 5 || r == 9 || r == 14 || r == 18 || r == 23, 1'b0};
      n_vec++;
      if ({busy, tick, done} !== e) begin
        n_err++;
        $display("FAIL loop r=%0d got btd=%b exp=%b", r, {busy, tick, done}, e);
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_vec++;
    if ({busy, tick, done, seg_idx, tick_idx} !== {3'b000, 2'd0, 16'd1}) begin
      n_err++;
      $display("FAIL loop_stop got b%b t%b d%b s%0d i%0d exp b0 t0 d0 s0 i1", busy, tick, done, seg_idx, tick_idx);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, tick, done} !== 3'b000) begin
      n_err++;
      $display("FAIL loop_idle got btd=%b exp=000", {busy, tick, done});
    end
  endtask

  task automatic test_d0_reconfig();
    logic [2:0] e;
    wr(2'd0, 32'd0, 16'd5);
    last_seg = 2'd0;
    loop = 1'b1;
    kick();
    for (int r = 0; r < 17; r++) begin
      if (r > 0) @(negedge clk);
      cfg_we = 1'b0;
      e = {1'b1, (r >= 2 && r <= 6) || r == 14, 1'b0};
      n_vec++;
      if ({busy, tick, done} !== e) begin
        n_err++;
        $display("FAIL d0_reconfig r=%0d got btd=%b exp=%b", r, {busy, tick, done}, e);
      end
      if (r == 3) begin
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_div = 32'd7;
        cfg_cnt = 16'd1;
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop = 1'b0;
  endtask

  task automatic test_priority();
    logic [2:0] e;
    wr(2'd0, 32'd3, 16'd4);
    last_seg = 2'd0;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (r > 0) @(negedge clk);
      n_vec++;
      if ({busy, tick, done} !== 3'b000) begin
        n_err++;
        $display("FAIL start_stop_idle r=%0d got btd=%b exp=000", r, {busy, tick, done});
      end
    end
    kick();
    for (int r = 0; r < 16; r++) begin
      if (r > 0) @(negedge clk);
      start = (r == 5);
      e = {r <= 13, r == 4 || r == 7 || r == 10 || r == 13, r == 14};
      n_vec++;
      if ({busy, tick, done} !== e) begin
        n_err++;
        $display("FAIL start_in_run r=%0d got btd=%b exp=%b", r, {busy, tick, done}, e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] e;
    wr(2'd0, 32'd1, 16'd1);
    wr(2'd1, 32'd3, 16'd3);
    last_seg = 2'd1;
    loop = 1'b0;
    kick();
    for (int r = 0; r < 7; r++) begin
      if (r > 0) @(negedge clk);
      e = {1'b1, r == 2 || r == 6, (r < 2) ? 2'd0 : 2'd1};
      n_vec++;
      if ({busy, tick, seg_idx} !== e) begin
        n_err++;
        $display("FAIL pre_reset r=%0d got bts=%b exp=%b", r, {busy, tick, seg_idx}, e);
      end
    end
    n_vec++;
    if (tick_idx !== 16'd1) begin
      n_err++;
      $display("FAIL pre_reset_tick_idx got %0d exp 1", tick_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, tick, done, seg_idx, tick_idx} !== 21'd0) begin
      n_err++;
      $display("FAIL async_reset got b%b t%b d%b s%0d i%0d exp all 0", busy, tick, done, seg_idx, tick_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick();
    for (int r = 0; r < 4; r++) begin
      if (r > 0) @(negedge clk);
      e = {r < 2, r == 2, (r == 0) ? 2'd0 : 2'd1};
      n_vec++;
      if ({busy, done, seg_idx} !== e) begin
        n_err++;
        $display("FAIL cleared_table r=%0d got bds=%b exp=%b", r, {busy, done, seg_idx}, e);
      end
      n_vec++;
      if (tick !== 1'b0) begin
        n_err++;
        $display("FAIL cleared_table_tick r=%0d got %b exp 0", r, tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_skip();
    test_loop();
    test_d0_reconfig();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
